core_eot_monitor: RTL and testbench

Synthesizable end-of-test monitor for the big_core family, generalised to NUM_HARTS instruction streams. Per hart, it delays the fetched instruction by a configurable number of pipeline stages so the check is made at commit, and detects EBREAK/ECALL. It terminates under an ANY-hart or ALL-harts policy, after a drain window, or on a cycle watchdog timeout. Sits beside the core in big_core_top; it drives status LEDs on FPGA and a finish hook in simulation.

---
 rtl/big_core_pkg.sv | 35 +++
 rtl/eot_inst_delay.sv | 56 +++++
 rtl/core_eot_monitor.sv | 186 ++++++++++++++++++
 tb/tb_core_eot_monitor.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/big_core_pkg.sv
// big_core_pkg
//   Shared definitions for the big_core end-of-test monitor:
//   - EBREAK / ECALL opcode constants
//   - t_eot_state : monitor FSM states (IDLE -> RUN -> DRAIN -> DONE)
//   - t_eot_cause : reason the test ended, as reported on EotCause
//   - stop_cause(): classifies a committing instruction as a stop opcode
package big_core_pkg;

  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;
  localparam logic [31:0] ECALL_INSTR  = 32'h00000073;

  typedef enum logic [1:0] {
    EOT_IDLE  = 2'd0,
    EOT_RUN   = 2'd1,
    EOT_DRAIN = 2'd2,
    EOT_DONE  = 2'd3
  } t_eot_state;

  typedef enum logic [1:0] {
    EOT_CAUSE_NONE    = 2'd0,
    EOT_CAUSE_EBREAK  = 2'd1,
    EOT_CAUSE_ECALL   = 2'd2,
    EOT_CAUSE_TIMEOUT = 2'd3
  } t_eot_cause;

  // Returns EBREAK/ECALL cause for a stop opcode, NONE otherwise.
  // ECALL only counts as a stop when ecall_en is set.
  function automatic t_eot_cause stop_cause(input logic [31:0] instr,
                                            input logic        ecall_en);
    if (instr == EBREAK_INSTR) return EOT_CAUSE_EBREAK;
    if (ecall_en && (instr == ECALL_INSTR)) return EOT_CAUSE_ECALL;
    return EOT_CAUSE_NONE;
  endfunction

endpackage

// File: rtl/eot_inst_delay.sv
// eot_inst_delay
//   DEPTH-stage {valid, data} shift pipe that carries one hart's fetched
//   instruction from Q101H to the commit point.
// Ports:
//   clk_i    core clock
//   rst_i    synchronous active-high reset, clears every valid bit
//   valid_i  instruction valid entering stage 0
//   data_i   instruction entering stage 0
//   flush_i  drops every in-flight entry and the one entering this cycle
//   valid_o  valid at the last stage (commit)
//   data_o   instruction at the last stage (commit)

`ifndef RVC_DFF
`define RVC_DFF(q, d, clk) always_ff @(posedge clk) q <= d;
`endif

`ifndef RVC_RST_DFF
`define RVC_RST_DFF(q, d, clk, rst) always_ff @(posedge clk) if (rst) q <= '0; else q <= d;
`endif

module eot_inst_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         flush_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][W-1:0] dat_q, dat_d;

  // Only the valid bits are cleared by flush; stale data behind an
  // invalid bit is never looked at.
  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = valid_i & ~flush_i;
    dat_d[0] = data_i;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1] & ~flush_i;
      dat_d[i] = dat_q[i-1];
    end
  end

  `RVC_RST_DFF(vld_q, vld_d, clk_i, rst_i)
  `RVC_DFF(dat_q, dat_d, clk_i)

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/core_eot_monitor.sv
// core_eot_monitor
//   End-of-test monitor for the big_core family. Each hart's fetched
//   instruction is delayed INST_DELAY cycles to its commit point, where
//   EBREAK (and optionally ECALL) stop that hart. The test ends when the
//   first hart stops (EOT_ALL=0) or all harts have stopped (EOT_ALL=1),
//   or when the cycle watchdog expires; a DRAIN_CYCLES window then
//   precedes the sticky EotDone.
// Ports:
//   Clk, Rst           clock, synchronous active-high reset
//   Enable             start the test (looked at only in IDLE)
//   InstValidQ101H     per-hart fetch valid
//   InstructionQ101H   per-hart instruction, hart h at [32h+31:32h]
//   FlushQ102H         per-hart flush of all in-flight entries
//   HartDone           sticky per-hart stopped flags
//   EotDone            sticky test-finished flag (state DONE)
//   EotCause           0 none, 1 ebreak, 2 ecall, 3 timeout
//   EotHartId          hart that ended the test (0 for timeout)
//   CycleCnt           cycles spent in RUN/DRAIN, saturating
//   RetireCnt          committed valid instructions across all harts
//   EotStateDbg        current FSM state (t_eot_state encoding)
module core_eot_monitor
  import big_core_pkg::*;
#(
  parameter int NUM_HARTS      = 1,
  parameter int INST_DELAY     = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32,
  parameter int DRAIN_CYCLES   = 4,
  parameter int EOT_ALL        = 0,
  parameter int ECALL_EN       = 0,
  localparam int HID_W         = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Enable,
  input  logic [NUM_HARTS-1:0]    InstValidQ101H,
  input  logic [NUM_HARTS*32-1:0] InstructionQ101H,
  input  logic [NUM_HARTS-1:0]    FlushQ102H,
  output logic [NUM_HARTS-1:0]    HartDone,
  output logic                    EotDone,
  output logic [1:0]              EotCause,
  output logic [HID_W-1:0]        EotHartId,
  output logic [CNT_W-1:0]        CycleCnt,
  output logic [CNT_W-1:0]        RetireCnt,
  output logic [1:0]              EotStateDbg
);

  localparam int DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

  // Commit-point view of every hart
  logic [NUM_HARTS-1:0]       cmt_vld;
  logic [NUM_HARTS-1:0][31:0] cmt_instr;

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    eot_inst_delay #(
      .DEPTH (INST_DELAY),
      .W     (32)
    ) u_dly (
      .clk_i   (Clk),
      .rst_i   (Rst),
      .valid_i (InstValidQ101H[g]),
      .data_i  (InstructionQ101H[32*g +: 32]),
      .flush_i (FlushQ102H[g]),
      .valid_o (cmt_vld[g]),
      .data_o  (cmt_instr[g])
    );
  end

  t_eot_state           state_q, state_d;
  logic [NUM_HARTS-1:0] hart_done_q, hart_done_d;
  logic [1:0]           cause_q, cause_d;
  logic [HID_W-1:0]     hid_q, hid_d;
  logic [CNT_W-1:0]     cyc_q, cyc_d;
  logic [CNT_W-1:0]     ret_q, ret_d;
  logic [DW-1:0]        drain_q, drain_d;

  logic                 active;
  logic [NUM_HARTS-1:0] stop_vec;
  logic                 stop_found;
  logic [HID_W-1:0]     stop_hid;
  t_eot_cause           stop_cse;
  t_eot_cause           hart_cse;
  logic                 term_stop;
  logic                 timeout;
  logic [CNT_W-1:0]     cyc_inc;

  // Commit check: commits are only observed while the test is live
  // (RUN or DRAIN); IDLE and DONE let the pipes shift unobserved.
  // The lowest-numbered stopping hart is reported when several stop
  // together.
  always_comb begin
    active     = (state_q == EOT_RUN) || (state_q == EOT_DRAIN);
    ret_d      = ret_q;
    stop_vec   = '0;
    stop_found = 1'b0;
    stop_hid   = '0;
    stop_cse   = EOT_CAUSE_NONE;
    hart_cse   = EOT_CAUSE_NONE;
    for (int h = 0; h < NUM_HARTS; h++) begin
      hart_cse = stop_cause(cmt_instr[h], ECALL_EN != 0);
      if (active && cmt_vld[h] && !hart_done_q[h]) begin
        ret_d = ret_d + CNT_W'(1);
        if (hart_cse != EOT_CAUSE_NONE) begin
          stop_vec[h] = 1'b1;
          if (!stop_found) begin
            stop_found = 1'b1;
            stop_hid   = HID_W'(h);
            stop_cse   = hart_cse;
          end
        end
      end
    end
    hart_done_d = hart_done_q | stop_vec;
  end

  // In ALL mode the hart stopping this cycle counts towards "all done",
  // so the last hart to stop is the one reported.
  assign term_stop = (EOT_ALL != 0) ? (&hart_done_d) : (|stop_vec);
  assign timeout   = (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);

  // Next-state logic; a stop beats a timeout landing on the same cycle.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hid_d   = hid_q;
    cyc_d   = cyc_q;
    drain_d = drain_q;
    unique case (state_q)
      EOT_IDLE: begin
        if (Enable) state_d = EOT_RUN;
      end
      EOT_RUN: begin
        cyc_d = cyc_inc;
        if (term_stop || timeout) begin
          cause_d = term_stop ? stop_cse : EOT_CAUSE_TIMEOUT;
          hid_d   = term_stop ? stop_hid : '0;
          drain_d = '0;
          state_d = (DRAIN_CYCLES == 0) ? EOT_DONE : EOT_DRAIN;
        end
      end
      EOT_DRAIN: begin
        cyc_d = cyc_inc;
        if (drain_q == DW'(DRAIN_LAST)) begin
          state_d = EOT_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      EOT_DONE: begin
        state_d = EOT_DONE;
      end
      default: state_d = EOT_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= EOT_IDLE;
      hart_done_q <= '0;
      cause_q     <= '0;
      hid_q       <= '0;
      cyc_q       <= '0;
      ret_q       <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      hart_done_q <= hart_done_d;
      cause_q     <= cause_d;
      hid_q       <= hid_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      drain_q     <= drain_d;
    end
  end

  assign HartDone    = hart_done_q;
  assign EotDone     = (state_q == EOT_DONE);
  assign EotCause    = cause_q;
  assign EotHartId   = hid_q;
  assign CycleCnt    = cyc_q;
  assign RetireCnt   = ret_q;
  assign EotStateDbg = state_q;

endmodule

// File: tb/tb_core_eot_monitor.sv
// Bench for core_eot_monitor. Four instances share one stimulus stream:
//   d0: 4 harts, ANY policy, ECALL off
//   d1: 4 harts, ALL policy, ECALL off
//   d2: 4 harts, ANY policy, ECALL on
//   d3: 1 hart (hart 0 of the stream), ANY policy, ECALL off
// All use INST_DELAY=2, DRAIN_CYCLES=4, TIMEOUT_CYCLES=50.
module tb_core_eot_monitor;

  localparam int D  = 2;
  localparam int TO = 50;
  localparam int DR = 4;
  localparam int M  = 2047;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] EBRK = 32'h00100073;
  localparam logic [31:0] ECLL = 32'h00000073;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [3:0]   vld = '0;
  logic [3:0]   fl  = '0;
  logic [127:0] ins = '0;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [3:0]  hd_0, hd_1, hd_2;
  logic        hd_3;
  logic        dn_0, dn_1, dn_2, dn_3;
  logic [1:0]  ca_0, ca_1, ca_2, ca_3;
  logic [1:0]  hi_0, hi_1, hi_2;
  logic        hi_3;
  logic [31:0] cy_0, cy_1, cy_2, cy_3;
  logic [31:0] rt_0, rt_1, rt_2, rt_3;
  logic [1:0]  st_0, st_1, st_2, st_3;

  core_eot_monitor #(.NUM_HARTS(4), .INST_DELAY(D), .TIMEOUT_CYCLES(TO), .CNT_W(32),
                     .DRAIN_CYCLES(DR), .EOT_ALL(0), .ECALL_EN(0)) d0 (
    .Clk(clk), .Rst(rst), .Enable(en), .InstValidQ101H(vld), .InstructionQ101H(ins),
    .FlushQ102H(fl), .HartDone(hd_0), .EotDone(dn_0), .EotCause(ca_0), .EotHartId(hi_0),
    .CycleCnt(cy_0), .RetireCnt(rt_0), .EotStateDbg(st_0));

  core_eot_monitor #(.NUM_HARTS(4), .INST_DELAY(D), .TIMEOUT_CYCLES(TO), .CNT_W(32),
                     .DRAIN_CYCLES(DR), .EOT_ALL(1), .ECALL_EN(0)) d1 (
    .Clk(clk), .Rst(rst), .Enable(en), .InstValidQ101H(vld), .InstructionQ101H(ins),
    .FlushQ102H(fl), .HartDone(hd_1), .EotDone(dn_1), .EotCause(ca_1), .EotHartId(hi_1),
    .CycleCnt(cy_1), .RetireCnt(rt_1), .EotStateDbg(st_1));

  core_eot_monitor #(.NUM_HARTS(4), .INST_DELAY(D), .TIMEOUT_CYCLES(TO), .CNT_W(32),
                     .DRAIN_CYCLES(DR), .EOT_ALL(0), .ECALL_EN(1)) d2 (
    .Clk(clk), .Rst(rst), .Enable(en), .InstValidQ101H(vld), .InstructionQ101H(ins),
    .FlushQ102H(fl), .HartDone(hd_2), .EotDone(dn_2), .EotCause(ca_2), .EotHartId(hi_2),
    .CycleCnt(cy_2), .RetireCnt(rt_2), .EotStateDbg(st_2));

  core_eot_monitor #(.NUM_HARTS(1), .INST_DELAY(D), .TIMEOUT_CYCLES(TO), .CNT_W(32),
                     .DRAIN_CYCLES(DR), .EOT_ALL(0), .ECALL_EN(0)) d3 (
    .Clk(clk), .Rst(rst), .Enable(en), .InstValidQ101H(vld[0]), .InstructionQ101H(ins[31:0]),
    .FlushQ102H(fl[0]), .HartDone(hd_3), .EotDone(dn_3), .EotCause(ca_3), .EotHartId(hi_3),
    .CycleCnt(cy_3), .RetireCnt(rt_3), .EotStateDbg(st_3));

  // ---------------- scoreboard counters ----------------
  int chk = 0;
  int err = 0;

  task automatic check(input string name, input int k, input longint act, input longint exp);
    chk++;
    if (act != exp) begin
      err++;
      $display("FAIL %s d%0d got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic read_dut(input int k, output int hd, output int dn, output int ca,
                          output int id, output int cc, output int rc, output int st);
    case (k)
      0: begin hd = int'(hd_0); dn = int'(dn_0); ca = int'(ca_0); id = int'(hi_0);
               cc = int'(cy_0); rc = int'(rt_0); st = int'(st_0); end
      1: begin hd = int'(hd_1); dn = int'(dn_1); ca = int'(ca_1); id = int'(hi_1);
               cc = int'(cy_1); rc = int'(rt_1); st = int'(st_1); end
      2: begin hd = int'(hd_2); dn = int'(dn_2); ca = int'(ca_2); id = int'(hi_2);
               cc = int'(cy_2); rc = int'(rt_2); st = int'(st_2); end
      default: begin hd = int'(hd_3); dn = int'(dn_3); ca = int'(ca_3); id = int'(hi_3);
               cc = int'(cy_3); rc = int'(rt_3); st = int'(st_3); end
    endcase
  endtask

  // ---------------- behavioural model ----------------
  // Input history per cycle; an instruction fetched in cycle t commits in
  // cycle t+D unless a flush or reset of its hart occurred in [t, t+D-1].
  logic [3:0]  h_v [2048];
  logic [3:0]  h_f [2048];
  logic        h_r [2048];
  logic [31:0] h_i [2048][4];
  int          cyc = 0;
  bit          live = 1'b0;

  int c_nh  [4] = '{4, 4, 4, 1};
  int c_all [4] = '{0, 1, 0, 0};
  int c_ec  [4] = '{0, 0, 1, 0};

  // phase: 0 idle, 1 run, 2 drain, 3 done
  int m_ph [4];
  int m_cc [4];
  int m_rc [4];
  int m_dn [4];
  int m_ca [4];
  int m_id [4];
  int m_dl [4];

  function automatic bit commits(input int h, input int t);
    if (t < D) return 1'b0;
    if (!h_v[(t-D) & M][h]) return 1'b0;
    for (int j = t - D; j < t; j++)
      if (h_f[j & M][h] || h_r[j & M]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input int k, input int t);
    int          stops;
    int          first_h;
    int          full;
    logic [31:0] w;
    logic [31:0] first_w;
    bit          live_phase;
    bit          term;
    if (h_r[t & M]) begin
      m_ph[k] = 0; m_cc[k] = 0; m_rc[k] = 0; m_dn[k] = 0;
      m_ca[k] = 0; m_id[k] = 0; m_dl[k] = 0;
      return;
    end
    live_phase = (m_ph[k] == 1) || (m_ph[k] == 2);
    stops   = 0;
    first_h = -1;
    first_w = '0;
    for (int h = 0; h < c_nh[k]; h++) begin
      if (live_phase && (((m_dn[k] >> h) & 1) == 0) && commits(h, t)) begin
        m_rc[k]++;
        w = h_i[(t-D) & M][h];
        if (w == EBRK || (c_ec[k] != 0 && w == ECLL)) begin
          stops |= (1 << h);
          if (first_h < 0) begin first_h = h; first_w = w; end
        end
      end
    end
    full = (1 << c_nh[k]) - 1;
    case (m_ph[k])
      0: if (en) m_ph[k] = 1;
      1: begin
        term = (c_all[k] != 0) ? ((m_dn[k] | stops) == full) : (stops != 0);
        if (term) begin
          m_ca[k] = (first_w == EBRK) ? 1 : 2;
          m_id[k] = first_h;
          m_ph[k] = 2;
          m_dl[k] = DR;
        end else if (m_cc[k] == TO - 1) begin
          m_ca[k] = 3;
          m_id[k] = 0;
          m_ph[k] = 2;
          m_dl[k] = DR;
        end
        m_cc[k]++;
      end
      2: begin
        m_cc[k]++;
        m_dl[k]--;
        if (m_dl[k] == 0) m_ph[k] = 3;
      end
      default: ;
    endcase
    m_dn[k] |= stops;
  endtask

  always @(posedge clk) begin : model_proc
    int s;
    s = cyc & M;
    h_v[s] = vld;
    h_f[s] = fl;
    h_r[s] = rst;
    for (int h = 0; h < 4; h++) h_i[s][h] = ins[32*h +: 32];
    if (rst) live = 1'b1;
    for (int k = 0; k < 4; k++) model_step(k, cyc);
    cyc++;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp_proc
    int hd, dn, ca, id, cc, rc, st;
    if (live) begin
      for (int k = 0; k < 4; k++) begin
        read_dut(k, hd, dn, ca, id, cc, rc, st);
        check("hart_done",  k, hd, m_dn[k]);
        check("eot_done",   k, dn, (m_ph[k] == 3) ? 1 : 0);
        check("eot_cause",  k, ca, m_ca[k]);
        check("eot_hartid", k, id, m_id[k]);
        check("cycle_cnt",  k, cc, m_cc[k]);
        check("retire_cnt", k, rc, m_rc[k]);
        check("state",      k, st, m_ph[k]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3, input logic [3:0] f);
    vld = v;
    ins = {w3, w2, w1, w0};
    fl  = f;
    tick();
    vld = '0;
    ins = '0;
    fl  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic start();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  // Hand-computed end-of-scenario expectations (done must be set).
  task automatic expect_out(input string tag, input int k, input int e_hd, input int e_ca,
                            input int e_id, input int e_cc, input int e_rc);
    int hd, dn, ca, id, cc, rc, st;
    read_dut(k, hd, dn, ca, id, cc, rc, st);
    check({tag, "_hart_done"},  k, hd, e_hd);
    check({tag, "_eot_done"},   k, dn, 1);
    check({tag, "_cause"},      k, ca, e_ca);
    check({tag, "_hartid"},     k, id, e_id);
    check({tag, "_cycle_cnt"},  k, cc, e_cc);
    check({tag, "_retire_cnt"}, k, rc, e_rc);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    logic [3:0]  v;
    logic [31:0] w [4];

    // 1) Ten NOPs then EBREAK on hart 0
    do_reset();
    start();
    for (int k = 1; k <= 10; k++) drive(4'b0001, NOP, NOP, NOP, NOP, 4'b0000);
    drive(4'b0001, EBRK, NOP, NOP, NOP, 4'b0000);
    n = 0;
    while (!hd_3 && n < 30) begin tick(); n++; end
    check("s1_hart_done_seen", 3, (n < 30) ? 1 : 0, 1);
    n = 0;
    while (!dn_3 && n < 30) begin tick(); n++; end
    check("s1_done_lag", 3, n, DR);
    idle(60);
    expect_out("s1", 3, 1, 1, 0, 17, 11);
    expect_out("s1", 0, 1, 1, 0, 17, 11);
    expect_out("s1", 1, 1, 3, 0, 54, 11);

    // 2) EBREAK on every hart, flushed the next cycle -> timeout
    do_reset();
    start();
    drive(4'b1111, EBRK, EBRK, EBRK, EBRK, 4'b0000);
    drive(4'b0000, NOP, NOP, NOP, NOP, 4'b1111);
    idle(60);
    for (int k = 0; k < 4; k++) expect_out("s2", k, 0, 3, 0, 54, 0);

    // 3) Harts 1 and 2 commit EBREAK in the same cycle
    do_reset();
    start();
    drive(4'b1111, NOP, NOP, NOP, NOP, 4'b0000);
    drive(4'b1111, NOP, NOP, NOP, NOP, 4'b0000);
    drive(4'b1111, NOP, EBRK, EBRK, NOP, 4'b0000);
    idle(60);
    expect_out("s3", 0, 4'b0110, 1, 1, 9, 12);
    expect_out("s3", 1, 4'b0110, 3, 0, 54, 12);
    expect_out("s3", 3, 1'b0, 3, 0, 54, 3);

    // 4) Staggered stops: hart h fetches EBREAK at k = 10*(h+1)
    do_reset();
    start();
    for (int k = 1; k <= 45; k++) begin
      v = 4'b0000;
      for (int h = 0; h < 4; h++) w[h] = NOP;
      if (k == 3) v[3] = 1'b1;
      if (k == 15 || k == 25) v[0] = 1'b1;
      for (int h = 0; h < 4; h++)
        if (k == 10 * (h + 1)) begin v[h] = 1'b1; w[h] = EBRK; end
      drive(v, w[0], w[1], w[2], w[3], 4'b0000);
      if (k == 35) check("s4_still_run", 1, int'(st_1), 1);
    end
    idle(20);
    expect_out("s4", 1, 4'b1111, 1, 3, 46, 5);

    // 5a) ECALL commit: ignored unless ECALL_EN
    do_reset();
    start();
    drive(4'b0001, ECLL, NOP, NOP, NOP, 4'b0000);
    idle(60);
    expect_out("s5a", 2, 4'b0001, 2, 0, 7, 1);
    expect_out("s5a", 0, 4'b0000, 3, 0, 54, 1);

    // 5b) EBREAK commits in the timeout cycle: stop wins
    do_reset();
    start();
    idle(47);
    drive(4'b0001, EBRK, NOP, NOP, NOP, 4'b0000);
    idle(20);
    expect_out("s5b", 0, 4'b0001, 1, 0, 54, 1);
    expect_out("s5b", 1, 4'b0001, 3, 0, 54, 1);

    // 6) Reset in the middle of DRAIN, then a clean re-run
    do_reset();
    start();
    drive(4'b0001, EBRK, NOP, NOP, NOP, 4'b0000);
    idle(2);
    check("s6_in_drain", 0, int'(st_0), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_rst_state",  0, int'(st_0), 0);
    check("s6_rst_hd",     0, int'(hd_0), 0);
    check("s6_rst_done",   0, int'(dn_0), 0);
    check("s6_rst_cause",  0, int'(ca_0), 0);
    check("s6_rst_cycles", 0, int'(cy_0), 0);
    check("s6_rst_retire", 0, int'(rt_0), 0);
    start();
    drive(4'b0001, EBRK, NOP, NOP, NOP, 4'b0000);
    idle(20);
    expect_out("s6", 0, 4'b0001, 1, 0, 7, 1);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
